// File: rtl/avalon_seg_writer_master_pkg.sv
// Shared types and constants for the 7-segment Avalon-MM writer.
package seg_avalon_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, WRITE} seg_wr_state_t;

  localparam int         SEG_AVM_DATA_W     = 32;
  localparam logic [3:0] SEG_AVM_BYTEENABLE = 4'b0001;

endpackage

// File: rtl/avalon_seg_writer_master_if.sv
// Value handshake plus Avalon-MM write bus; master = writer side, slave = environment side.
interface avalon_seg_writer_master_if #(
  parameter int NUM_SEGMENT = 6,
  parameter int ADDR_W      = 3
);
  import seg_avalon_pkg::*;

  logic [NUM_SEGMENT*4-1:0]  value_i;
  logic                      value_valid_i;
  logic                      value_ready_o;
  logic                      done_o;
  logic [ADDR_W-1:0]         avm_address_o;
  logic [3:0]                avm_byteenable_o;
  logic                      avm_write_o;
  logic [SEG_AVM_DATA_W-1:0] avm_writedata_o;
  logic                      avm_waitrequest_i;

  modport master (
    input  value_i, value_valid_i, avm_waitrequest_i,
    output value_ready_o, done_o, avm_address_o, avm_byteenable_o,
           avm_write_o, avm_writedata_o
  );

  modport slave (
    output value_i, value_valid_i, avm_waitrequest_i,
    input  value_ready_o, done_o, avm_address_o, avm_byteenable_o,
           avm_write_o, avm_writedata_o
  );

endinterface

// File: rtl/avalon_seg_writer_master.sv
// Writes one hex digit per Avalon word (addr = digit index), all outputs registered.
// SEG_WRITER_SKIP_UNCHANGED_EN: skip digits equal to a shadow of the last written value.
module avalon_seg_writer_master
  import seg_avalon_pkg::*;
#(
  parameter int NUM_SEGMENT = 6,
  parameter int ADDR_W      = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  avalon_seg_writer_master_if.master  bus
);

  localparam int               IDX_W    = (NUM_SEGMENT > 1) ? $clog2(NUM_SEGMENT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SEGMENT - 1);

  seg_wr_state_t             r_state;
  logic [IDX_W-1:0]          r_idx;
  logic [NUM_SEGMENT*4-1:0]  r_value;
  logic                      r_ready;
  logic                      r_done;
  logic [ADDR_W-1:0]         r_addr;
  logic [3:0]                r_be;
  logic                      r_write;
  logic [SEG_AVM_DATA_W-1:0] r_wdata;

  logic [3:0]                w_digit;
  logic                      w_sel;
  logic                      w_last;

  always_comb begin
    w_digit = 4'h0;
    for (int k = 0; k < NUM_SEGMENT; k++) begin
      if (r_idx == IDX_W'(k)) w_digit = r_value[k*4 +: 4];
    end
  end

  assign w_last = (r_idx == LAST_IDX);

`ifdef SEG_WRITER_SKIP_UNCHANGED_EN
  logic [NUM_SEGMENT*4-1:0] r_shadow;
  logic [3:0]               w_shadow_digit;

  always_comb begin
    w_shadow_digit = 4'h0;
    for (int k = 0; k < NUM_SEGMENT; k++) begin
      if (r_idx == IDX_W'(k)) w_shadow_digit = r_shadow[k*4 +: 4];
    end
  end

  assign w_sel = (w_digit != w_shadow_digit);

  // Shadow mirrors the slave: only accepted writes update it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else if (r_state == WRITE && !bus.avm_waitrequest_i) begin
      for (int k = 0; k < NUM_SEGMENT; k++) begin
        if (r_idx == IDX_W'(k)) r_shadow[k*4 +: 4] <= r_wdata[3:0];
      end
    end
  end
`else
  assign w_sel = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_value <= '0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_addr  <= '0;
      r_be    <= 4'h0;
      r_write <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          if (bus.value_valid_i && r_ready) begin
            r_value <= bus.value_i;
            r_idx   <= '0;
            r_ready <= 1'b0;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          if (w_sel) begin
            r_addr  <= ADDR_W'(r_idx);
            r_wdata <= {{(SEG_AVM_DATA_W-4){1'b0}}, w_digit};
            r_be    <= SEG_AVM_BYTEENABLE;
            r_write <= 1'b1;
            r_state <= WRITE;
          end else if (w_last) begin
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        WRITE: begin
          // Address/data/byteenable hold until the slave drops waitrequest.
          if (!bus.avm_waitrequest_i) begin
            r_write <= 1'b0;
            r_be    <= 4'h0;
            if (w_last) begin
              r_done  <= 1'b1;
              r_ready <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= SCAN;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.value_ready_o    = r_ready;
  assign bus.done_o           = r_done;
  assign bus.avm_address_o    = r_addr;
  assign bus.avm_byteenable_o = r_be;
  assign bus.avm_write_o      = r_write;
  assign bus.avm_writedata_o  = r_wdata;

endmodule

// File: tb/tb_avalon_seg_writer_master.sv
// Directed-vector bench for avalon_seg_writer_master; expected write masks depend on SEG_WRITER_SKIP_UNCHANGED_EN.
module tb_avalon_seg_writer_master;
  import seg_avalon_pkg::*;

  localparam int NUM_SEGMENT = 6;
  localparam int ADDR_W      = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  avalon_seg_writer_master_if #(.NUM_SEGMENT(NUM_SEGMENT), .ADDR_W(ADDR_W)) bus();

  avalon_seg_writer_master #(.NUM_SEGMENT(NUM_SEGMENT), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  typedef struct {
    logic [23:0] v;
    int          st_addr;
    int          st_len;
    logic        pulse;
    logic [5:0]  mask_all;
    logic [5:0]  mask_skip;
  } vec_t;

  wr_t  wq[$];
  int   done_cnt = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  vec_t tbl[7];

  logic        prev_stall = 1'b0;
  logic [2:0]  prev_addr;
  logic [31:0] prev_data;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Bus monitor: records accepted writes, done pulses, and stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {bus.avm_write_o, bus.avm_address_o, bus.avm_writedata_o},
              {1'b1, prev_addr, prev_data});
      if (bus.done_o) begin
        done_cnt++;
        check("ready_with_done", bus.value_ready_o, 1'b1);
      end
      if (bus.avm_write_o && !bus.avm_waitrequest_i)
        wq.push_back('{bus.avm_address_o, bus.avm_writedata_o, bus.avm_byteenable_o});
      prev_stall = bus.avm_write_o && bus.avm_waitrequest_i;
      prev_addr  = bus.avm_address_o;
      prev_data  = bus.avm_writedata_o;
    end
  end

  task automatic compare_writes(input logic [23:0] v, input logic [5:0] mask);
    int k = 0;
    int n = 0;
    logic [23:0] vv = v;
    for (int a = 0; a < NUM_SEGMENT; a++) begin
      if (mask[a]) begin
        n++;
        if (k < wq.size()) begin
          check("wr_addr", 64'(wq[k].addr), 64'(a));
          check("wr_data", 64'(wq[k].data), {60'h0, vv[a*4 +: 4]});
          check("wr_be",   64'(wq[k].be),   64'h1);
        end
        k++;
      end
    end
    check("wr_count", 64'(wq.size()), 64'(n));
  endtask

  task automatic run_value(input logic [23:0] v, input int st_addr, input int st_len,
                           input logic pulse, input logic [5:0] mask);
    int cyc  = 0;
    int left = st_len;
    wq.delete();
    done_cnt = 0;
    check("ready_before", bus.value_ready_o, 1'b1);
    bus.value_i       = v;
    bus.value_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.value_valid_i = 1'b0;
    bus.value_i       = '0;
    check("ready_fall", bus.value_ready_o, 1'b0);
    while (done_cnt == 0 && cyc < 200) begin
      if (mask[0] && st_addr != 0 && cyc < 2)
        check("first_write_lat", bus.avm_write_o, (cyc == 1));
      bus.avm_waitrequest_i = bus.avm_write_o && (int'(bus.avm_address_o) == st_addr) && (left > 0);
      if (bus.avm_waitrequest_i) left--;
      if (pulse && cyc == 3) begin
        bus.value_i       = 24'hFFFFFF;
        bus.value_valid_i = 1'b1;
      end else begin
        bus.value_valid_i = 1'b0;
        bus.value_i       = '0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.avm_waitrequest_i = 1'b0;
    bus.value_valid_i     = 1'b0;
    check("done_seen", (cyc < 200), 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("done_once", 64'(done_cnt), 64'd1);
    check("ready_after", bus.value_ready_o, 1'b1);
    compare_writes(v, mask);
  endtask

  initial begin
    logic [5:0] m;
    int         cyc;

    tbl[0] = '{24'h123456, -1, 0, 1'b1, 6'h3F, 6'h3F};
    tbl[1] = '{24'h123956,  2, 3, 1'b0, 6'h3F, 6'h04};
    tbl[2] = '{24'h123956, -1, 0, 1'b0, 6'h3F, 6'h00};
    tbl[3] = '{24'h654321,  5, 1, 1'b0, 6'h3F, 6'h3F};
    tbl[4] = '{24'h123456,  2, 3, 1'b0, 6'h3F, 6'h3F};
    tbl[5] = '{24'hAAAAAA,  0, 2, 1'b0, 6'h3F, 6'h3F};
    tbl[6] = '{24'hA0A0A0, -1, 0, 1'b0, 6'h3F, 6'h15};

    bus.value_i           = '0;
    bus.value_valid_i     = 1'b0;
    bus.avm_waitrequest_i = 1'b0;

    // Reset state and ready rise.
    @(negedge clk); @(negedge clk);
    check("reset_outputs",
          {bus.value_ready_o, bus.done_o, bus.avm_address_o, bus.avm_byteenable_o,
           bus.avm_write_o, bus.avm_writedata_o}, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("ready_before_edge", bus.value_ready_o, 1'b0);
    @(posedge clk); #1;
    check("ready_after_edge", bus.value_ready_o, 1'b1);

    for (int i = 0; i < 7; i++) begin
`ifdef SEG_WRITER_SKIP_UNCHANGED_EN
      m = tbl[i].mask_skip;
`else
      m = tbl[i].mask_all;
`endif
      run_value(tbl[i].v, tbl[i].st_addr, tbl[i].st_len, tbl[i].pulse, m);
    end

    // Reset asserted while the addr-3 write is stalled.
    wq.delete();
    done_cnt          = 0;
    bus.value_i       = 24'h654321;
    bus.value_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.value_valid_i = 1'b0;
    cyc = 0;
    while (!(bus.avm_write_o && bus.avm_address_o == 3'd3) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("reach_addr3", (cyc < 100), 1'b1);
    bus.avm_waitrequest_i = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_write_drop", bus.avm_write_o, 1'b0);
    check("rst_no_done", bus.done_o, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs",
          {bus.value_ready_o, bus.avm_address_o, bus.avm_byteenable_o, bus.avm_writedata_o}, 64'h0);
    bus.avm_waitrequest_i = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready_back", bus.value_ready_o, 1'b1);
    check("rst_done_count", 64'(done_cnt), 64'd0);
`ifdef SEG_WRITER_SKIP_UNCHANGED_EN
    run_value(24'h000001, -1, 0, 1'b0, 6'h01);
`else
    run_value(24'h000001, -1, 0, 1'b0, 6'h3F);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
